// File: rtl/bcd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_ctrl_pkg
//  Shared definitions for the BCD conversion scheduler: FSM state encoding,
//  result/digit widths and the default binary operand width.
//  No ports (package).
// ---------------------------------------------------------------------------
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int BCD_W     = 16;  // four digits {tho,hun,ten,one}
   localparam int DIGIT_W   = 4;
   localparam int BIN_W_DEF = 10;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//  Combinational round-robin pick. Scans ptr+1, ptr+2, .. (mod N) and returns
//  the first channel with req set, so the channel at ptr has lowest priority.
// Ports
//  req      in   N    request vector
//  ptr      in   PW   index of the last served channel
//  gnt_oh   out  N    one-hot grant (zero when nothing requested)
//  gnt_idx  out  PW   index of the granted channel
//  gnt_vld  out  1    some request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic [PW-1:0] idx;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      // Walk from the farthest offset back to the nearest so the nearest
      // pending channel after ptr is the one left standing.
      for (int i = N; i >= 1; i--) begin
         idx = PW'((int'(ptr) + i) % N);
         if (req[idx]) begin
            gnt_oh      = '0;
            gnt_oh[idx] = 1'b1;
            gnt_idx     = idx;
            gnt_vld     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// ---------------------------------------------------------------------------
// bcd_conv_scheduler
//  Shares one external sequential binary-to-BCD converter among N channels.
//  Channels are granted round-robin; the granted operand is latched, the
//  converter is started and its result is stored in a per-channel register.
//  A conversion that does not finish within TIMEOUT cycles is abandoned.
// Ports
//  clk, rst_n   clock, asynchronous active-low reset
//  req          N        per-channel level request, held until ack
//  bin_flat     N*BIN_W  channel i operand at [i*BIN_W +: BIN_W]
//  ack          N        one-cycle pulse, channel result register updated
//  bcd_flat     N*16     channel i result {tho,hun,ten,one} at [i*16 +: 16]
//  busy         1        FSM not in IDLE
//  err_timeout  1        one-cycle pulse on an abandoned conversion
//  cv_start     1        start strobe to the converter
//  cv_bin       BIN_W    operand to the converter, held until the result
//  cv_done      1        converter result strobe
//  cv_bcd       16       converter result, valid with cv_done
// ---------------------------------------------------------------------------
module bcd_conv_scheduler
   import bcd_ctrl_pkg::*;
#(
   parameter int N       = 4,
   parameter int BIN_W   = BIN_W_DEF,
   parameter int TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       req,
   input  logic [N*BIN_W-1:0] bin_flat,
   output logic [N-1:0]       ack,
   output logic [N*BCD_W-1:0] bcd_flat,
   output logic               busy,
   output logic               err_timeout,
   output logic               cv_start,
   output logic [BIN_W-1:0]   cv_bin,
   input  logic               cv_done,
   input  logic [BCD_W-1:0]   cv_bcd
);

   localparam int PW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT);

   state_e           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    gidx_q, gidx_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [N-1:0]     ack_q, ack_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [BIN_W-1:0] cv_bin_q, cv_bin_d;
   logic             cv_start_q, cv_start_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [BCD_W-1:0] bcd_q [N];
   logic [BCD_W-1:0] bcd_d [N];

   logic [N-1:0]     arb_oh;
   logic [PW-1:0]    arb_idx;
   logic             arb_vld;

   rr_arbiter #(.N(N), .PW(PW)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      gnt_d      = gnt_q;
      timer_d    = timer_q;
      cv_bin_d   = cv_bin_q;
      bcd_d      = bcd_q;
      ack_d      = '0;
      err_d      = 1'b0;
      cv_start_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (arb_vld) begin
               gnt_d      = arb_oh;
               gidx_d     = arb_idx;
               cv_bin_d   = bin_flat[arb_idx*BIN_W +: BIN_W];
               cv_start_d = 1'b1;  // high for the single ISSUE cycle
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cv_done) begin
               bcd_d[gidx_q] = cv_bcd;
               ack_d         = gnt_q;  // ack is visible during DONE
               state_d       = S_DONE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               // Abandoned channel becomes lowest priority, same as a served one.
               err_d   = 1'b1;
               ptr_d   = gidx_q;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DONE: begin
            ptr_d   = gidx_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= PW'(N - 1);
         gidx_q     <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         timer_q    <= '0;
         cv_bin_q   <= '0;
         cv_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < N; i++) bcd_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         timer_q    <= timer_d;
         cv_bin_q   <= cv_bin_d;
         cv_start_q <= cv_start_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         bcd_q      <= bcd_d;
      end
   end

   assign ack         = ack_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;
   assign cv_start    = cv_start_q;
   assign cv_bin      = cv_bin_q;

   for (genvar g = 0; g < N; g++) begin : g_bcd
      assign bcd_flat[g*BCD_W +: BCD_W] = bcd_q[g];
   end

endmodule
